// File: rtl/spi_slave_param.sv
// spi_slave_param: parametrised SPI slave supporting all four CPOL/CPHA modes.
// It receives a cmd/addr/payload frame MSB first on mosi. At the same time it
// shifts a reply frame out on miso, taken from a one-deep valid/ready buffer.
// All pin inputs are resynchronised into the sysclk domain. All decisions are
// made on edges of the synchronised sclk/cs.
//
// Optional build macro SPI_SLAVE_MISO_TRISTATE_EN:
//   defined   -> miso floats (1'bz) whenever the slave is not mid-frame
//   undefined -> miso is driven low in those states
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | cs high, waiting for a cs falling edge to start a frame
// ACTIVE  | frame in progress, shifting rx/tx on sample/shift edges
// DONE    | one cycle: publish received fields and pulse rx_dv
// WAIT_CS | frame complete (or cs already low at reset), wait for cs high
module spi_slave_param #(
    parameter int CMD_BITS     = 8,
    parameter int ADDR_BITS    = 8,
    parameter int PAYLOAD_BITS = 8,
    parameter int CPOL         = 0,
    parameter int CPHA         = 0,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                                        sysclk,
    input  logic                                        rst_n,
    input  logic                                        sclk,
    input  logic                                        cs,
    input  logic                                        mosi,
    output logic                                        miso,
    input  logic                                        tx_valid,
    output logic                                        tx_ready,
    input  logic [CMD_BITS+ADDR_BITS+PAYLOAD_BITS-1:0]  i_tx_frame,
    output logic [CMD_BITS-1:0]                         o_cmd,
    output logic [ADDR_BITS-1:0]                        o_addr,
    output logic [PAYLOAD_BITS-1:0]                     o_payload,
    output logic                                        rx_dv,
    output logic                                        o_frame_err,
    output logic                                        o_tx_underrun
);

    localparam int FRAME_WIDTH = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;
    localparam int CNT_W       = $clog2(FRAME_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_WIDTH - 1);
    localparam logic IDLE_LVL  = (CPOL != 0);
    localparam logic SHIFT_LEAD = (CPHA != 0);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACTIVE  = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;
    localparam logic [1:0] WAIT_CS = 2'd3;

    logic [1:0]             rst_sync;
    logic                   rst_int_n;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_q;
    logic                   cs_q;
    logic                   lead_edge;
    logic                   trail_edge;
    logic                   sample_edge;
    logic                   shift_edge;
    logic                   cs_fall;

    logic [1:0]             state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [FRAME_WIDTH-1:0] rx_shift;
    logic [FRAME_WIDTH-1:0] tx_shift;
    logic                   miso_q;
    logic                   drive;

    logic                   buf_full;
    logic [FRAME_WIDTH-1:0] buf_data;
    logic                   accept;
    logic                   start;
    logic [FRAME_WIDTH-1:0] start_frame;

    // Reset asserts immediately but is released only on a clock edge.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    // Resynchronise the asynchronous SPI pins. cs resets low on purpose, so a
    // cs that is already low when reset is released does not look like a
    // falling edge; the FSM parks in WAIT_CS instead.
    always_ff @(posedge sysclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sclk_sync <= {SYNC_STAGES{IDLE_LVL}};
            cs_sync   <= '0;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Keep the previous synchronised levels for edge detection.
    always_ff @(posedge sysclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sclk_q <= IDLE_LVL;
            cs_q   <= 1'b0;
        end else begin
            sclk_q <= sclk_s;
            cs_q   <= cs_s;
        end
    end

    assign lead_edge   = (sclk_q == IDLE_LVL) && (sclk_s != IDLE_LVL);
    assign trail_edge  = (sclk_q != IDLE_LVL) && (sclk_s == IDLE_LVL);
    assign sample_edge = SHIFT_LEAD ? trail_edge : lead_edge;
    assign shift_edge  = SHIFT_LEAD ? lead_edge : trail_edge;
    assign cs_fall     = cs_q && !cs_s;

    assign tx_ready = !buf_full;
    assign accept   = tx_valid && !buf_full;
    assign start    = (state == IDLE) && cs_fall;

    // A frame accepted in the same cycle a frame starts bypasses the buffer.
    assign start_frame = buf_full ? buf_data : (accept ? i_tx_frame : '0);

    // One-deep reply holding buffer; a frame start always leaves it empty.
    always_ff @(posedge sysclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else if (start) begin
            buf_full <= 1'b0;
        end else if (accept) begin
            buf_full <= 1'b1;
            buf_data <= i_tx_frame;
        end
    end

    // Frame sequencing, rx/tx shifting and the output pulses.
    always_ff @(posedge sysclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            rx_shift      <= '0;
            tx_shift      <= '0;
            miso_q        <= 1'b0;
            o_cmd         <= '0;
            o_addr        <= '0;
            o_payload     <= '0;
            rx_dv         <= 1'b0;
            o_frame_err   <= 1'b0;
            o_tx_underrun <= 1'b0;
        end else begin
            rx_dv         <= 1'b0;
            o_frame_err   <= 1'b0;
            o_tx_underrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state         <= ACTIVE;
                        bit_cnt       <= '0;
                        tx_shift      <= start_frame;
                        o_tx_underrun <= !buf_full && !accept;
                        // With CPHA=0 the master samples on the first edge,
                        // so the MSB must already be on the line.
                        miso_q        <= SHIFT_LEAD ? 1'b0 : start_frame[FRAME_WIDTH-1];
                    end else if (!cs_s) begin
                        state <= WAIT_CS;
                    end
                end
                ACTIVE: begin
                    if (cs_s) begin
                        state       <= IDLE;
                        o_frame_err <= 1'b1;
                        miso_q      <= 1'b0;
                    end else if (sample_edge) begin
                        rx_shift <= {rx_shift[FRAME_WIDTH-2:0], mosi_s};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state  <= DONE;
                            miso_q <= 1'b0;
                        end
                    end else if (shift_edge) begin
                        // CPHA=1 presents the current MSB on the shift edge;
                        // CPHA=0 already showed it, so move to the next bit.
                        miso_q   <= SHIFT_LEAD ? tx_shift[FRAME_WIDTH-1]
                                               : tx_shift[FRAME_WIDTH-2];
                        tx_shift <= {tx_shift[FRAME_WIDTH-2:0], 1'b0};
                    end
                end
                DONE: begin
                    o_cmd     <= rx_shift[FRAME_WIDTH-1 -: CMD_BITS];
                    o_addr    <= rx_shift[ADDR_BITS+PAYLOAD_BITS-1 -: ADDR_BITS];
                    o_payload <= rx_shift[PAYLOAD_BITS-1:0];
                    rx_dv     <= 1'b1;
                    state     <= WAIT_CS;
                end
                default: begin
                    if (cs_s) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign drive = !cs_s && ((state == ACTIVE) || (state == DONE));

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign miso = drive ? miso_q : 1'bz;
`else
    assign miso = drive & miso_q;
`endif

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: one instance per SPI mode (index = {CPOL,CPHA}),
// driven by a bit-banged master with a shared mode-0-polarity base clock.
module tb_spi_slave_param;

    localparam int HALF = 8;
    localparam logic [7:0] CMD_LED_SET = 8'h01;

    logic        sysclk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        sclk_b = 1'b0;
    logic        mosi   = 1'b0;
    logic [3:0]  cs_v   = 4'hF;
    logic [3:0]  tx_valid_v = 4'h0;
    logic [23:0] tx_frame = 24'h0;
    logic [3:0]  miso_v, tx_ready_v, rx_dv_v, ferr_v, unr_v;
    logic [7:0]  cmd_v [4];
    logic [7:0]  addr_v [4];
    logic [7:0]  pay_v [4];
    int          n_dv [4] = '{0, 0, 0, 0};
    int          n_fe [4] = '{0, 0, 0, 0};
    int          n_un [4] = '{0, 0, 0, 0};
    int          s_dv, s_fe, s_un;
    logic [31:0] rx_bits;
    int          checks = 0;
    int          errors = 0;

    always #4 sysclk = ~sysclk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int POL = g / 2;
        localparam int PHA = g % 2;
        logic sclk_g;
        assign sclk_g = sclk_b ^ (POL != 0);
        spi_slave_param #(.CPOL(POL), .CPHA(PHA)) u_dut (
            .sysclk        (sysclk),
            .rst_n         (rst_n),
            .sclk          (sclk_g),
            .cs            (cs_v[g]),
            .mosi          (mosi),
            .miso          (miso_v[g]),
            .tx_valid      (tx_valid_v[g]),
            .tx_ready      (tx_ready_v[g]),
            .i_tx_frame    (tx_frame),
            .o_cmd         (cmd_v[g]),
            .o_addr        (addr_v[g]),
            .o_payload     (pay_v[g]),
            .rx_dv         (rx_dv_v[g]),
            .o_frame_err   (ferr_v[g]),
            .o_tx_underrun (unr_v[g])
        );
    end

    // Count pulses per instance.
    always @(posedge sysclk) begin
        for (int i = 0; i < 4; i++) begin
            if (rx_dv_v[i]) n_dv[i] <= n_dv[i] + 1;
            if (ferr_v[i])  n_fe[i] <= n_fe[i] + 1;
            if (unr_v[i])   n_un[i] <= n_un[i] + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    function automatic logic bit_of(input logic [23:0] d, input int i);
        return (i < 24) ? d[23 - i] : 1'b0;
    endfunction

    task automatic snap(input int m);
        s_dv = n_dv[m];
        s_fe = n_fe[m];
        s_un = n_un[m];
    endtask

    task automatic load(input int m, input logic [23:0] f);
        tx_frame      = f;
        tx_valid_v[m] = 1'b1;
        tick(1);
        tx_valid_v[m] = 1'b0;
        check_val("tx_ready_after_load", 32'(tx_ready_v[m]), 32'h0);
    endtask

    task automatic cs_low(input int m, input logic [23:0] d);
        cs_v[m] = 1'b0;
        if (m % 2 == 0) mosi = d[23];
        tick(HALF);
    endtask

    task automatic clk_bits(input int m, input int s, input int e, input logic [23:0] d);
        for (int i = s; i < e; i++) begin
            sclk_b = 1'b1;
            if (m % 2 == 1) mosi = bit_of(d, i);
            else            rx_bits = {rx_bits[30:0], miso_v[m]};
            tick(HALF);
            sclk_b = 1'b0;
            if (m % 2 == 1) rx_bits = {rx_bits[30:0], miso_v[m]};
            else            mosi = bit_of(d, i + 1);
            tick(HALF);
        end
    endtask

    task automatic cs_high(input int m);
        cs_v[m] = 1'b1;
        tick(4 * HALF);
    endtask

    task automatic xfer(input int m, input int n, input logic [23:0] d);
        rx_bits = 32'h0;
        cs_low(m, d);
        clk_bits(m, 0, n, d);
        cs_high(m);
    endtask

    initial begin
        tick(5);
        rst_n = 1'b1;
        tick(10);

        for (int m = 0; m < 4; m++) begin
            check_val("rst_tx_ready", 32'(tx_ready_v[m]), 32'h1);
            check_val("rst_rx_dv",    32'(rx_dv_v[m]),    32'h0);
            check_val("rst_miso",     32'(miso_v[m]),     32'h0);
            check_val("rst_fields",   32'({cmd_v[m], addr_v[m], pay_v[m]}), 32'h0);
        end

        // Mode 0 LED command.
        snap(0);
        load(0, 24'h00000A);
        xfer(0, 24, {CMD_LED_SET, 8'h09, 8'h05});
        check_val("m0_dv_count", 32'(n_dv[0] - s_dv), 32'd1);
        check_val("m0_cmd",      32'(cmd_v[0]),  32'(CMD_LED_SET));
        check_val("m0_addr",     32'(addr_v[0]), 32'h09);
        check_val("m0_payload",  32'(pay_v[0]),  32'h05);
        check_val("m0_reply",    32'(rx_bits[23:0]), 32'h00000A);
        check_val("m0_underrun", 32'(n_un[0] - s_un), 32'd0);
        check_val("m0_frame_err", 32'(n_fe[0] - s_fe), 32'd0);
        check_val("m0_tx_ready_end", 32'(tx_ready_v[0]), 32'h1);

        // Modes 1, 2, 3.
        for (int m = 1; m < 4; m++) begin
            snap(m);
            load(m, 24'h5A3C7E);
            xfer(m, 24, 24'hA5C381);
            check_val("mode_dv_count", 32'(n_dv[m] - s_dv), 32'd1);
            check_val("mode_fields",   32'({cmd_v[m], addr_v[m], pay_v[m]}), 32'hA5C381);
            check_val("mode_reply",    32'(rx_bits[23:0]), 32'h5A3C7E);
        end

        // Abort after 13 bits, then a full frame.
        snap(0);
        xfer(0, 13, 24'hFFFFFF);
        check_val("abort_frame_err", 32'(n_fe[0] - s_fe), 32'd1);
        check_val("abort_no_dv",     32'(n_dv[0] - s_dv), 32'd0);
        check_val("abort_fields_kept", 32'({cmd_v[0], addr_v[0], pay_v[0]}),
                  32'({CMD_LED_SET, 8'h09, 8'h05}));
        snap(0);
        xfer(0, 24, 24'h010203);
        check_val("after_abort_dv", 32'(n_dv[0] - s_dv), 32'd1);
        check_val("after_abort_fields", 32'({cmd_v[0], addr_v[0], pay_v[0]}), 32'h010203);
        check_val("after_abort_no_err", 32'(n_fe[0] - s_fe), 32'd0);

        // Underrun: nothing loaded.
        snap(0);
        xfer(0, 24, 24'hFFFFFF);
        check_val("underrun_pulse", 32'(n_un[0] - s_un), 32'd1);
        check_val("underrun_reply", 32'(rx_bits[23:0]), 32'h000000);
        check_val("underrun_dv",    32'(n_dv[0] - s_dv), 32'd1);
        check_val("underrun_fields", 32'({cmd_v[0], addr_v[0], pay_v[0]}), 32'hFFFFFF);

        // 28 clocks in one cs window; reload the buffer mid-frame.
        load(0, 24'hC0FFEE);
        snap(0);
        fork
            xfer(0, 28, 24'h123456);
            begin
                tick(100);
                load(0, 24'h13579B);
            end
        join
        check_val("long_tx_ready_low", 32'(tx_ready_v[0]), 32'h0);
        check_val("long_dv_once",   32'(n_dv[0] - s_dv), 32'd1);
        check_val("long_fields",    32'({cmd_v[0], addr_v[0], pay_v[0]}), 32'h123456);
        check_val("long_reply",     32'(rx_bits[27:4]), 32'hC0FFEE);
        check_val("long_tail_zero", 32'(rx_bits[3:0]), 32'h0);
        check_val("long_no_err",    32'(n_fe[0] - s_fe), 32'd0);
        snap(0);
        xfer(0, 24, 24'h0A0B0C);
        check_val("next_reply",     32'(rx_bits[23:0]), 32'h13579B);
        check_val("next_tx_ready",  32'(tx_ready_v[0]), 32'h1);
        check_val("next_no_underrun", 32'(n_un[0] - s_un), 32'd0);

        // Reset at bit 10 with cs held low.
        load(0, 24'h111111);
        snap(0);
        rx_bits = 32'h0;
        cs_low(0, 24'hABCDEF);
        clk_bits(0, 0, 10, 24'hABCDEF);
        rst_n = 1'b0;
        tick(3);
        check_val("midrst_fields",   32'({cmd_v[0], addr_v[0], pay_v[0]}), 32'h0);
        check_val("midrst_tx_ready", 32'(tx_ready_v[0]), 32'h1);
        check_val("midrst_miso",     32'(miso_v[0]), 32'h0);
        rst_n = 1'b1;
        tick(HALF);
        clk_bits(0, 10, 24, 24'hABCDEF);
        check_val("midrst_no_dv",  32'(n_dv[0] - s_dv), 32'd0);
        check_val("midrst_no_err", 32'(n_fe[0] - s_fe), 32'd0);
        cs_high(0);
        check_val("midrst_no_err_cs_high", 32'(n_fe[0] - s_fe), 32'd0);
        check_val("midrst_no_dv_cs_high",  32'(n_dv[0] - s_dv), 32'd0);
        load(0, 24'h2468AC);
        snap(0);
        xfer(0, 24, 24'h3C5A69);
        check_val("postrst_dv",     32'(n_dv[0] - s_dv), 32'd1);
        check_val("postrst_fields", 32'({cmd_v[0], addr_v[0], pay_v[0]}), 32'h3C5A69);
        check_val("postrst_reply",  32'(rx_bits[23:0]), 32'h2468AC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
